rx_iq_sample_fifo: RTL and testbench
====================================

// Module: rx_iq_sample_fifo
// PURPOSE
// Consumes the decimated I/Q stream from the rx channel (avail strobe plus IN_WIDTH-bit I and Q) in the adc_clk domain.
// Buffers samples in a ring memory and serves them as 16-bit words in three-word groups: I[15:0], Q[15:0], {I[MSB-:8],Q[MSB-:8]}.
// Flags a block-ready condition for the CPU drain loop. Reports sticky overflow when samples arrive with the buffer full.
// PARAMETERS
// IN_WIDTH    24   width of in_i/in_q; must be >= 16
// DEPTH_LOG2  9    log2 of ring depth in samples (512)
// NSAMPS      170  ready threshold in samples; 1..2**DEPTH_LOG2
// PORTS
// adc_clk    in   1               sole clock
// reset      in   1               synchronous, active-high
// in_strobe  in   1               one-cycle pulse, in_i/in_q valid
// in_i       in   IN_WIDTH        signed I sample
// in_q       in   IN_WIDTH        signed Q sample
// rd_strobe  in   1               consume current rd_dout word
// rd_dout    out  16              current output word (registered)
// rd_valid   out  1               rd_dout holds a valid word
// count      out  DEPTH_LOG2+1    whole samples stored, including partially-read head
// ready      out  1               count >= NSAMPS
// overflow   out  1               sticky: a sample was dropped
// clr_ovfl   in   1               clears overflow
// BEHAVIOUR
// - Reset: wr_ptr=rd_ptr=0, count=0, word phase=0, rd_dout=0, rd_valid=0, ready=0, overflow=0. Memory contents are not cleared.
// - Storage: one 2*IN_WIDTH entry {I,Q} per sample; inferred block RAM with synchronous read.
// - Write: if in_strobe && count<DEPTH, write at wr_ptr and increment wr_ptr (wraps mod DEPTH).
// - Drop: if in_strobe && count==DEPTH, discard the sample and set overflow.
//   - Full is judged on the pre-cycle count, so the sample is dropped even if a pop occurs in the same cycle.
// - Read fetch: when rd_valid=0 and count>0, issue a RAM read at rd_ptr.
//   - Head register loads one cycle later. rd_valid=1 and rd_dout=word0 on the following cycle.
//   - Fetch latency is 2 cycles from the non-empty condition.
// - Word phase 0: I[15:0]; 1: Q[15:0]; 2: {I[IN_WIDTH-1-:8], Q[IN_WIDTH-1-:8]}.
// - rd_strobe with rd_valid=1:
//   - Phase 0 or 1: phase+1; rd_dout updates on the next cycle and rd_valid stays 1.
//   - Phase 2: phase=0, rd_ptr+1 (wraps), count-1, rd_valid=0; the next fetch starts if count>0 after the pop.
// - rd_strobe with rd_valid=0: ignored, with no state change. The CPU must poll rd_valid between words.
// - Simultaneous accepted write and phase-2 pop: count unchanged, both pointers advance.
// - count decrements only on the phase-2 pop, so a partially read head sample still counts.
// - ready is combinational from count; it deasserts as soon as count < NSAMPS.
// - overflow: set has priority over a same-cycle clr_ovfl. clr_ovfl with no drop in that cycle clears it.
// - Reset asserted mid-read discards buffered data and the partial phase; all state returns to reset values on the next edge.
// - No read-during-write hazard: a fetch targets rd_ptr only when count>0, so it never addresses the slot being written while the buffer is empty.
// TESTING
// - Reset, then 1 sample I=24'h123456, Q=24'hABCDEF:
//   - rd_valid rises 2 cycles after the write.
//   - Words are 16'h3456, 16'hCDEF, 16'h12AB on three rd_strobes.
//   - count then reads 0.
// - Write 170 samples with no reads:
//   - ready=1 on the cycle after the 170th write.
//   - Reading 3 words drops count to 169 and ready to 0.
// - Write 513 samples with no reads: count=512, overflow=1. The first word read is from sample 0.
// - Pulse clr_ovfl in the same cycle as a dropped sample: overflow stays 1. A later clr_ovfl clears it.
// - Continuous in_strobe every 4 cycles with concurrent reads:
//   - Cross pointer wrap at 512 (run for 2000 samples).
//   - Word sequence matches a scoreboard; count is stable on cycles with a simultaneous write and pop.
// - Assert reset after 1 word of a sample has been read: count=0, rd_valid=0, overflow=0. Post-reset writes read back correctly from word 0.

Source files
------------

// File: rtl/rx_iq_sample_fifo.sv
// rx_iq_sample_fifo: buffers decimated I/Q samples from the rx channel
// and serves each one to the CPU as three 16-bit words.
//
// Ports (all in the adc_clk domain):
//   adc_clk    sole clock
//   reset      synchronous, active-high
//   in_strobe  one-cycle pulse, in_i/in_q valid
//   in_i/in_q  IN_WIDTH-bit signed I and Q sample
//   rd_strobe  consume the current rd_dout word
//   rd_dout    current output word, registered
//   rd_valid   rd_dout holds a valid word
//   count      whole samples stored, including a partially read head
//   ready      count >= NSAMPS
//   overflow   sticky: a sample was dropped
//   clr_ovfl   clears overflow
module rx_iq_sample_fifo #(
    parameter int IN_WIDTH   = 24,
    parameter int DEPTH_LOG2 = 9,
    parameter int NSAMPS     = 170
) (
    input  logic                  adc_clk,
    input  logic                  reset,
    input  logic                  in_strobe,
    input  logic [IN_WIDTH-1:0]   in_i,
    input  logic [IN_WIDTH-1:0]   in_q,
    input  logic                  rd_strobe,
    output logic [15:0]           rd_dout,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ready,
    output logic                  overflow,
    input  logic                  clr_ovfl
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = 2 * IN_WIDTH;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_CNT  = CW'(NSAMPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } rd_state_t;

    rd_state_t state, state_nx;

    logic [SW-1:0]         mem [DEPTH];
    logic [SW-1:0]         ram_q;
    logic [SW-1:0]         head;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            phase;

    logic full;
    logic push;
    logic drop;
    logic take;
    logic pop;
    logic rd_en;

    // Word layout: I low, Q low, then the top bytes of I and Q.
    function automatic logic [15:0] sel_word(
        input logic [SW-1:0] s,
        input logic [1:0]    p
    );
        logic [IN_WIDTH-1:0] si;
        logic [IN_WIDTH-1:0] sq;
        si = s[SW-1:IN_WIDTH];
        sq = s[IN_WIDTH-1:0];
        case (p)
            2'd0:    return si[15:0];
            2'd1:    return sq[15:0];
            2'd2:    return {si[IN_WIDTH-1-:8], sq[IN_WIDTH-1-:8]};
            default: return 16'h0000;
        endcase
    endfunction

    // Fullness uses the pre-cycle count, so a same-cycle pop
    // does not make room for an incoming sample.
    assign full     = (count == FULL_CNT);
    assign push     = in_strobe && !full;
    assign drop     = in_strobe && full;
    assign rd_valid = (state == S_HOLD);
    assign take     = rd_strobe && rd_valid;
    assign pop      = take && (phase == 2'd2);
    assign ready    = (count >= RDY_CNT);

    // A fetch only targets rd_ptr when count > 0, so it never
    // reads the slot being written into an empty buffer.
    assign rd_en = (state == S_IDLE) && (count != '0);

    always_ff @(posedge adc_clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_i, in_q};
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (pop) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            phase    <= 2'd0;
            rd_dout  <= 16'h0000;
            head     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (state == S_FETCH) begin
                head    <= ram_q;
                rd_dout <= sel_word(ram_q, 2'd0);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                phase  <= 2'd0;
            end else if (take) begin
                phase   <= phase + 2'd1;
                rd_dout <= sel_word(head, phase + 2'd1);
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovfl) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_iq_sample_fifo.sv
// tb_rx_iq_sample_fifo: directed bench for rx_iq_sample_fifo.
// Inputs change and outputs are sampled on the falling edge.
module tb_rx_iq_sample_fifo;

    logic        adc_clk;
    logic        reset;
    logic        in_strobe;
    logic [23:0] in_i;
    logic [23:0] in_q;
    logic        rd_strobe;
    logic [15:0] rd_dout;
    logic        rd_valid;
    logic [9:0]  count;
    logic        ready;
    logic        overflow;
    logic        clr_ovfl;

    int n_checks = 0;
    int n_errors = 0;

    rx_iq_sample_fifo #(
        .IN_WIDTH   (24),
        .DEPTH_LOG2 (9),
        .NSAMPS     (170)
    ) dut (
        .adc_clk   (adc_clk),
        .reset     (reset),
        .in_strobe (in_strobe),
        .in_i      (in_i),
        .in_q      (in_q),
        .rd_strobe (rd_strobe),
        .rd_dout   (rd_dout),
        .rd_valid  (rd_valid),
        .count     (count),
        .ready     (ready),
        .overflow  (overflow),
        .clr_ovfl  (clr_ovfl)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk_i(input int n);
        logic [7:0] a;
        a = 8'(n);
        return {a ^ 8'h5A, 16'(n * 7 + 3)};
    endfunction

    function automatic logic [23:0] mk_q(input int n);
        logic [7:0] a;
        a = 8'(n);
        return {a ^ 8'hC3, 16'(n * 13 + 5)};
    endfunction

    function automatic logic [15:0] exp_word(input int n, input int ph);
        logic [23:0] i;
        logic [23:0] q;
        i = mk_i(n);
        q = mk_q(n);
        if (ph == 0) return i[15:0];
        if (ph == 1) return q[15:0];
        return {i[23:16], q[23:16]};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(negedge adc_clk);
        @(negedge adc_clk);
        reset = 1'b0;
    endtask

    task automatic write_n(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            in_strobe = 1'b1;
            in_i = mk_i(base + k);
            in_q = mk_q(base + k);
            @(negedge adc_clk);
        end
        in_strobe = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic [15:0] exp);
        int t;
        t = 0;
        while (!rd_valid && t < 20) begin
            @(negedge adc_clk);
            t++;
        end
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_dout), 32'(exp));
        rd_strobe = 1'b1;
        @(negedge adc_clk);
        rd_strobe = 1'b0;
    endtask

    initial begin
        int  nw;
        int  nr;
        int  ph;
        int  cyc;
        int  cb;
        bit  wr;
        bit  rd;
        bit  pop;

        reset = 1'b1;
        in_strobe = 1'b0;
        in_i = '0;
        in_q = '0;
        rd_strobe = 1'b0;
        clr_ovfl = 1'b0;
        @(negedge adc_clk);
        do_reset();

        chk("rst_dout", 32'(rd_dout), 32'h0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ovfl", 32'(overflow), 32'd0);

        // single sample, fetch latency and word order
        in_strobe = 1'b1;
        in_i = 24'h123456;
        in_q = 24'hABCDEF;
        @(negedge adc_clk);
        in_strobe = 1'b0;
        chk("t1_cnt1", 32'(count), 32'd1);
        chk("t1_vld_c1", 32'(rd_valid), 32'd0);
        @(negedge adc_clk);
        chk("t1_vld_c2", 32'(rd_valid), 32'd0);
        @(negedge adc_clk);
        chk("t1_vld_c3", 32'(rd_valid), 32'd1);
        read_word("t1_w0", 16'h3456);
        read_word("t1_w1", 16'hCDEF);
        read_word("t1_w2", 16'h12AB);
        chk("t1_cnt0", 32'(count), 32'd0);
        chk("t1_vld0", 32'(rd_valid), 32'd0);

        // ready threshold
        do_reset();
        write_n(0, 169);
        chk("t2_cnt169", 32'(count), 32'd169);
        chk("t2_rdy169", 32'(ready), 32'd0);
        write_n(169, 1);
        chk("t2_cnt170", 32'(count), 32'd170);
        chk("t2_rdy170", 32'(ready), 32'd1);
        read_word("t2_w0", exp_word(0, 0));
        read_word("t2_w1", exp_word(0, 1));
        chk("t2_rdy_part", 32'(ready), 32'd1);
        read_word("t2_w2", exp_word(0, 2));
        chk("t2_cnt_pop", 32'(count), 32'd169);
        chk("t2_rdy_pop", 32'(ready), 32'd0);

        // overflow and clear priority
        do_reset();
        write_n(0, 513);
        chk("t3_cnt", 32'(count), 32'd512);
        chk("t3_ovfl", 32'(overflow), 32'd1);
        in_strobe = 1'b1;
        clr_ovfl = 1'b1;
        @(negedge adc_clk);
        in_strobe = 1'b0;
        clr_ovfl = 1'b0;
        chk("t4_ovfl_keep", 32'(overflow), 32'd1);
        chk("t4_cnt_keep", 32'(count), 32'd512);
        clr_ovfl = 1'b1;
        @(negedge adc_clk);
        clr_ovfl = 1'b0;
        chk("t4_ovfl_clr", 32'(overflow), 32'd0);
        read_word("t3_w0", exp_word(0, 0));
        read_word("t3_w1", exp_word(0, 1));
        chk("t4_w2", 32'(rd_dout), 32'(exp_word(0, 2)));
        // drop on full even with a same-cycle pop
        rd_strobe = 1'b1;
        in_strobe = 1'b1;
        in_i = 24'hFFFFFF;
        in_q = 24'hFFFFFF;
        @(negedge adc_clk);
        rd_strobe = 1'b0;
        in_strobe = 1'b0;
        chk("t4_pop_cnt", 32'(count), 32'd511);
        chk("t4_pop_ovfl", 32'(overflow), 32'd1);
        read_word("t4_next", exp_word(1, 0));

        // streaming across the pointer wrap
        do_reset();
        nw = 0;
        nr = 0;
        ph = 0;
        cyc = 0;
        while (nr < 2000 && cyc < 20000) begin
            wr = (cyc % 4 == 0) && (nw < 2000);
            rd = rd_valid;
            pop = rd && (ph == 2);
            cb = int'(count);
            if (rd) begin
                chk("stream_word", 32'(rd_dout), 32'(exp_word(nr, ph)));
                if (ph == 2) begin
                    ph = 0;
                    nr++;
                end else begin
                    ph++;
                end
            end
            in_strobe = wr;
            if (wr) begin
                in_i = mk_i(nw);
                in_q = mk_q(nw);
                nw++;
            end
            rd_strobe = rd;
            @(negedge adc_clk);
            if (wr && pop) begin
                chk("stream_cnt_stable", 32'(count), 32'(cb));
            end
            cyc++;
        end
        in_strobe = 1'b0;
        rd_strobe = 1'b0;
        chk("stream_done", 32'(nr), 32'd2000);
        chk("stream_cnt", 32'(count), 32'd0);
        chk("stream_ovfl", 32'(overflow), 32'd0);

        // reset in the middle of a sample
        write_n(0, 1);
        read_word("t6_w0", exp_word(0, 0));
        chk("t6_mid_cnt", 32'(count), 32'd1);
        reset = 1'b1;
        @(negedge adc_clk);
        reset = 1'b0;
        chk("t6_rst_cnt", 32'(count), 32'd0);
        chk("t6_rst_vld", 32'(rd_valid), 32'd0);
        chk("t6_rst_ovfl", 32'(overflow), 32'd0);
        write_n(100, 2);
        read_word("t6_a0", exp_word(100, 0));
        read_word("t6_a1", exp_word(100, 1));
        read_word("t6_a2", exp_word(100, 2));
        read_word("t6_b0", exp_word(101, 0));
        read_word("t6_b1", exp_word(101, 1));
        read_word("t6_b2", exp_word(101, 2));
        chk("t6_cnt_end", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
